shared_ram_arbiter: RTL and testbench

Two-port arbiter that time-shares one single-port 8-bit scratch block RAM (the generated `blk_mem_gen_0` class of memory, one-cycle read latency) between the master and slave kcpsm6 processors. Each processor's port-decode glue presents a request with address, write-enable and write data. The arbiter grants requests round-robin with an optional bounded lock for burst ownership, drives the RAM and returns read data per requester. It lets the slave reach the constant/scratch store the master currently owns alone.

---
 rtl/shared_ram_arbiter.sv | 126 ++++++++++++
 tb/tb_shared_ram_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter with bounded lock, time-sharing one single-port RAM
// (one-cycle read latency) between a master and a slave requester.
module shared_ram_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_we,
  input  logic              m_lock,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  input  logic              s_req,
  input  logic              s_we,
  input  logic              s_lock,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            r_state, w_next;
  logic              r_last;       // 0 = master, 1 = slave; also the current winner
  logic              r_win_lock;
  logic [CW-1:0]     r_lock_cnt;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_m_rvalid, r_s_rvalid;
  logic [DATA_W-1:0] r_m_rdata, r_s_rdata;

  logic          w_any, w_both, w_keep, w_sel, w_sel_lock, w_arb;
  logic [CW-1:0] w_cnt_nxt;

  // Arbitration: single requester, then bounded lock, then round-robin.
  always_comb begin
    w_any      = m_req | s_req;
    w_both     = m_req & s_req;
    w_keep     = w_both & r_win_lock & (r_lock_cnt < LOCK_LIM);
    w_sel      = 1'b0;
    if (!w_both)     w_sel = s_req;
    else if (w_keep) w_sel = r_last;
    else             w_sel = ~r_last;
    w_sel_lock = w_sel ? s_lock : m_lock;
    w_cnt_nxt  = r_lock_cnt;
    if ((w_sel != r_last) || !w_sel_lock) w_cnt_nxt = '0;
    else if (w_keep)                      w_cnt_nxt = r_lock_cnt + 1'b1;
    w_arb      = (r_state == IDLE) && w_any;
  end

  always_comb begin
    w_next = r_state;
    m_gnt  = 1'b0;
    s_gnt  = 1'b0;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE: begin
        m_gnt  = ~r_last;
        s_gnt  = r_last;
        w_next = r_ram_we ? IDLE : CAPTURE;
      end
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_win_lock  <= 1'b0;
      r_lock_cnt  <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_m_rvalid  <= 1'b0;
      r_s_rvalid  <= 1'b0;
      r_m_rdata   <= '0;
      r_s_rdata   <= '0;
    end else begin
      r_state    <= w_next;
      r_ram_en   <= w_arb;
      r_m_rvalid <= (r_state == CAPTURE) && !r_last;
      r_s_rvalid <= (r_state == CAPTURE) && r_last;
      if (w_arb) begin
        r_last      <= w_sel;
        r_win_lock  <= w_sel_lock;
        r_lock_cnt  <= w_cnt_nxt;
        r_ram_we    <= w_sel ? s_we    : m_we;
        r_ram_addr  <= w_sel ? s_addr  : m_addr;
        r_ram_wdata <= w_sel ? s_wdata : m_wdata;
      end
      if (r_state == CAPTURE) begin
        if (r_last) r_s_rdata <= ram_rdata;
        else        r_m_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign m_rvalid  = r_m_rvalid;
  assign s_rvalid  = r_s_rvalid;
  assign m_rdata   = r_m_rdata;
  assign s_rdata   = r_s_rdata;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: RAM model, grant/read-data scoreboard and
// directed timing checks for read, write, round-robin, lock, reset and withdraw.
module tb_shared_ram_arbiter;

  logic       clock, reset;
  logic       m_req, m_we, m_lock, s_req, s_we, s_lock;
  logic [5:0] m_addr, s_addr, ram_addr;
  logic [7:0] m_wdata, s_wdata, m_rdata, s_rdata, ram_wdata, ram_rdata;
  logic       m_gnt, m_rvalid, s_gnt, s_rvalid, ram_en, ram_we;

  shared_ram_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_lock(s_lock), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0, ngnt = 0, nsgnt = 0;
  logic [7:0] mem [64];
  logic [7:0] sh  [64];
  bit         exp_gnt [$];
  logic [7:0] rdq_m [$];
  logic [7:0] rdq_s [$];
  int         gcyc [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Block RAM model: registered read, one-cycle latency.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard monitor: grant order, issued access, read data per requester.
  always @(negedge clock) begin
    if (reset) begin
      exp_gnt.delete(); rdq_m.delete(); rdq_s.delete();
    end else begin
      if (m_gnt || s_gnt) begin
        chk("gnt_excl", {m_gnt, s_gnt}, {1'b0, s_gnt} | {~s_gnt, 1'b0});
        chk("gnt_en", ram_en, 1);
        chk("gnt_addr", ram_addr, s_gnt ? s_addr : m_addr);
        if (exp_gnt.size() > 0) chk("gnt_who", s_gnt, exp_gnt.pop_front());
        else                    chk("gnt_unexpected", 1, 0);
        if (ram_we)     sh[ram_addr] = ram_wdata;
        else if (s_gnt) rdq_s.push_back(sh[ram_addr]);
        else            rdq_m.push_back(sh[ram_addr]);
        gcyc.push_back(cyc);
        ngnt++;
        if (s_gnt) nsgnt++;
      end
      if (m_rvalid) begin
        if (rdq_m.size() > 0) chk("m_rdata", m_rdata, rdq_m.pop_front());
        else                  chk("m_rvalid_unexpected", 1, 0);
      end
      if (s_rvalid) begin
        if (rdq_s.size() > 0) chk("s_rdata", s_rdata, rdq_s.pop_front());
        else                  chk("s_rvalid_unexpected", 1, 0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic access(input bit who, input bit we, input logic [5:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    if (who) begin s_we = we; s_addr = a; s_wdata = d; s_req = 1'b1; end
    else     begin m_we = we; m_addr = a; m_wdata = d; m_req = 1'b1; end
    exp_gnt.push_back(who);
    @(negedge clock); chk("acc_T", {m_gnt, s_gnt, ram_en}, 0);
    @(negedge clock); chk("acc_T1", {m_gnt, s_gnt, ram_en, ram_we}, {!who, who, 1'b1, we});
    chk("acc_T1_ad", {ram_addr, we ? ram_wdata : 8'h00}, {a, we ? d : 8'h00});
    @(posedge clock); #1 m_req = 1'b0; s_req = 1'b0;
    @(negedge clock); chk("acc_T2", {m_gnt, s_gnt, ram_en, m_rvalid, s_rvalid}, 0);
    if (!we) begin
      @(negedge clock); chk("acc_T3", {m_rvalid, s_rvalid}, {!who, who});
    end
  endtask

  task automatic wait_gnts(input int n, input int budget);
    int t = 0;
    while (ngnt < n && t < budget) begin @(posedge clock); t++; end
    chk("wait_gnt", ngnt >= n, 1);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < 64; i++) begin mem[i] = 8'(i); sh[i] = 8'(i); end
    mem[5] = 8'hA5; sh[5] = 8'hA5; mem[10] = 8'h5A; sh[10] = 8'h5A;
    reset = 1'b1; m_req = 0; m_we = 0; m_lock = 0; m_addr = 0; m_wdata = 0;
    s_req = 0; s_we = 0; s_lock = 0; s_addr = 0; s_wdata = 0;
    repeat (2) @(negedge clock);
    chk("rst_outs", {m_gnt, s_gnt, m_rvalid, s_rvalid, ram_en, ram_we, ram_addr,
                     ram_wdata, m_rdata, s_rdata}, 0);
    @(posedge clock); #1 reset = 1'b0;

    // single master read of preloaded location
    access(0, 0, 6'd5, 8'h00);
    chk("rd_a5", m_rdata, 8'hA5);
    chk("rd_s_quiet", s_rdata, 8'h00);

    // slave write then read back; master data untouched
    access(1, 1, 6'd63, 8'h3C);
    @(negedge clock); chk("wr_en_once", ram_en, 0);
    access(1, 0, 6'd63, 8'h00);
    chk("wr_rd_3c", s_rdata, 8'h3C);
    chk("wr_m_keep", m_rdata, 8'hA5);

    // tie after reset: m, s, m, s, three cycles apart
    do_reset();
    gcyc.delete();
    base = ngnt;
    @(posedge clock); #1;
    m_we = 0; s_we = 0; m_addr = 6'd5; s_addr = 6'd10; m_req = 1; s_req = 1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    wait_gnts(base + 4, 40);
    m_req = 0; s_req = 0;
    for (int i = 1; i < 4 && i < gcyc.size(); i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);
    repeat (4) @(negedge clock);
    chk("rr_data", {m_rdata, s_rdata}, {8'hA5, 8'h5A});

    // bounded lock: five master grants, then slave, then master
    base = ngnt;
    @(posedge clock); #1; m_lock = 1; m_req = 1; s_req = 1;
    for (int i = 0; i < 5; i++) exp_gnt.push_back(0);
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    wait_gnts(base + 7, 60);
    m_req = 0; s_req = 0; m_lock = 0;
    repeat (4) @(negedge clock);
    chk("lock_q", exp_gnt.size(), 0);

    // reset in the CAPTURE cycle of a master read
    @(posedge clock); #1 m_addr = 6'd5; m_req = 1; exp_gnt.push_back(0);
    @(posedge clock); #1 m_req = 0;
    @(posedge clock); #1 reset = 1'b1;
    #1 chk("rst_mid", {m_gnt, s_gnt, m_rvalid, s_rvalid, ram_en, ram_we, ram_addr,
                       ram_wdata, m_rdata, s_rdata}, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); chk("rst_norv", {m_rvalid, s_rvalid}, 0);
    base = ngnt;
    @(posedge clock); #1 m_req = 1; s_req = 1; exp_gnt.push_back(0);
    wait_gnts(base + 1, 10);
    m_req = 0; s_req = 0;
    chk("rst_tie_m", gcyc.size() > 0 ? 1 : 0, 1);
    repeat (4) @(negedge clock);

    // slave request pulsed only while master's access is in ISSUE
    base = nsgnt;
    @(posedge clock); #1 m_addr = 6'd5; m_req = 1; exp_gnt.push_back(0);
    @(posedge clock); #1 m_req = 0; s_req = 1;
    @(posedge clock); #1 s_req = 0;
    repeat (6) @(negedge clock);
    chk("wd_no_sgnt", nsgnt - base, 0);
    chk("wd_idle", {ram_en, m_gnt, s_gnt}, 0);

    chk("sb_empty", exp_gnt.size() + rdq_m.size() + rdq_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
